// File: rtl/gpio_input_debouncer.sv
// Conditions raw board inputs for the gpioA read port: a 2-FF synchroniser and a counter debounce filter per bit,
// with registered rise/fall pulses, sticky change flags (software clear) and a combined interrupt.
module gpio_input_debouncer #(
    parameter int               WIDTH           = 8,
    parameter int               DEBOUNCE_CYCLES = 1000000,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             io_mainClk,
    input  logic             io_asyncResetn,
    input  logic [WIDTH-1:0] io_pins,
    output logic [WIDTH-1:0] io_read,
    output logic [WIDTH-1:0] io_rise,
    output logic [WIDTH-1:0] io_fall,
    output logic [WIDTH-1:0] io_changed,
    input  logic [WIDTH-1:0] io_clear,
    output logic             io_irq
);

    localparam int                   CNT_WIDTH = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    logic [WIDTH-1:0] sync_s1;
    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] accept;

    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            sync_s1 <= RESET_VALUE;
            sync_s  <= RESET_VALUE;
        end else begin
            sync_s1 <= io_pins;
            sync_s  <= sync_s1;
        end
    end

    // Acceptance resets the counter on the same edge, so it never climbs past CNT_MAX.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CNT_WIDTH-1:0] cnt;

        assign accept[i] = (sync_s[i] != io_read[i]) && (cnt == CNT_MAX);

        always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
            if (!io_asyncResetn) begin
                cnt <= '0;
            end else if ((sync_s[i] == io_read[i]) || accept[i]) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    // A newly accepted change outranks a clear landing on the same edge.
    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            io_read    <= RESET_VALUE;
            io_rise    <= '0;
            io_fall    <= '0;
            io_changed <= '0;
        end else begin
            io_read    <= io_read ^ accept;
            io_rise    <= accept & sync_s;
            io_fall    <= accept & ~sync_s;
            io_changed <= (io_changed & ~io_clear) | accept;
        end
    end

    assign io_irq = |io_changed;

endmodule

// File: tb/tb_gpio_input_debouncer.sv
// Bench for gpio_input_debouncer (WIDTH=8, DEBOUNCE_CYCLES=4): expected pulse events are queued as stimulus is
// driven and matched by a monitor against the cycle and pattern the DUT actually produces.
module tb_gpio_input_debouncer;

    logic       clk;
    logic       rst_n;
    logic [7:0] pins;
    logic [7:0] clear;
    logic [7:0] read_o;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] changed;
    logic       irq;

    int checks = 0;
    int passes = 0;
    int edge_cnt = 0;
    logic [31:0] exp_q[$];

    gpio_input_debouncer #(
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (4),
        .RESET_VALUE     (8'h00)
    ) dut (
        .io_mainClk     (clk),
        .io_asyncResetn (rst_n),
        .io_pins        (pins),
        .io_read        (read_o),
        .io_rise        (rise),
        .io_fall        (fall),
        .io_changed     (changed),
        .io_clear       (clear),
        .io_irq         (irq)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack_evt(input int c, input logic [7:0] r, input logic [7:0] f);
        return {c[15:0], r, f};
    endfunction

    // ---------------- scoreboard monitor ----------------
    always begin
        logic [31:0] exp_evt;
        logic [31:0] got_evt;
        @(posedge clk);
        #1;
        checks++;
        if ((rise & fall) !== 8'h00) begin
            $display("FAIL rise_fall_exclusive: cycle=%0d rise=%h fall=%h, required no common bit", edge_cnt, rise, fall);
        end else begin
            passes++;
        end
        if ((rise | fall) !== 8'h00) begin
            got_evt = pack_evt(edge_cnt, rise, fall);
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_pulse: cycle=%0d rise=%h fall=%h, required no pulse", edge_cnt, rise, fall);
            end else begin
                exp_evt = exp_q.pop_front();
                if (got_evt !== exp_evt) begin
                    $display("FAIL pulse_event: got cycle=%0d rise=%h fall=%h, required cycle=%0d rise=%h fall=%h",
                             got_evt[31:16], got_evt[15:8], got_evt[7:0], exp_evt[31:16], exp_evt[15:8], exp_evt[7:0]);
                end else begin
                    passes++;
                end
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        pins  = 8'h00;
        clear = 8'h00;
        repeat (3) tick();
        checks++;
        if ({read_o, rise, fall, changed, irq} !== 33'h0) begin
            $display("FAIL reset_hold: read=%h rise=%h fall=%h changed=%h irq=%b, required all 0", read_o, rise, fall, changed, irq);
        end else begin
            passes++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({read_o, rise, fall, changed, irq} !== 33'h0) begin
                $display("FAIL reset_idle: cycle=%0d read=%h changed=%h irq=%b, required all 0", i, read_o, changed, irq);
            end else begin
                passes++;
            end
        end
    endtask

    task automatic test_single_rise();
        int m;
        @(negedge clk);
        pins = 8'h01;
        m = edge_cnt;
        exp_q.push_back(pack_evt(m + 6, 8'h01, 8'h00));
        repeat (5) tick();
        checks++;
        if (read_o !== 8'h00) begin
            $display("FAIL rise_early: read=%h, required 00", read_o);
        end else begin
            passes++;
        end
        tick();
        checks++;
        if ({read_o, changed, irq} !== {8'h01, 8'h01, 1'b1}) begin
            $display("FAIL rise_accept: read=%h changed=%h irq=%b, required 01 01 1", read_o, changed, irq);
        end else begin
            passes++;
        end
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL rise_missing: %0d pulses outstanding, required 0", exp_q.size());
        end else begin
            passes++;
        end
    endtask

    task automatic test_glitch_reject();
        int m;
        @(negedge clk);
        pins = 8'h09;
        repeat (3) tick();
        @(negedge clk);
        pins = 8'h01;
        repeat (10) tick();
        checks++;
        if ((read_o !== 8'h01) || (exp_q.size() != 0)) begin
            $display("FAIL glitch_3cyc: read=%h queue=%0d, required 01 and 0", read_o, exp_q.size());
        end else begin
            passes++;
        end
        @(negedge clk);
        pins = 8'h09;
        m = edge_cnt;
        exp_q.push_back(pack_evt(m + 6, 8'h08, 8'h00));
        repeat (4) tick();
        @(negedge clk);
        pins = 8'h01;
        m = edge_cnt;
        exp_q.push_back(pack_evt(m + 6, 8'h00, 8'h08));
        repeat (12) tick();
        checks++;
        if ((read_o !== 8'h01) || (exp_q.size() != 0)) begin
            $display("FAIL glitch_4cyc: read=%h queue=%0d, required 01 and 0", read_o, exp_q.size());
        end else begin
            passes++;
        end
    endtask

    task automatic test_bounce();
        int m;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pins[5] = ~pins[5];
            repeat (2) tick();
        end
        @(negedge clk);
        pins[5] = 1'b1;
        m = edge_cnt;
        exp_q.push_back(pack_evt(m + 6, 8'h20, 8'h00));
        repeat (8) tick();
        checks++;
        if ((read_o !== 8'h21) || (exp_q.size() != 0)) begin
            $display("FAIL bounce: read=%h queue=%0d, required 21 and 0", read_o, exp_q.size());
        end else begin
            passes++;
        end
    endtask

    task automatic test_random_glitch();
        logic [7:0] base;
        base = pins;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            pins = base ^ 8'($urandom_range(1, 255));
            repeat ($urandom_range(1, 3)) tick();
            @(negedge clk);
            pins = base;
            repeat ($urandom_range(1, 3)) tick();
        end
        repeat (8) tick();
        checks++;
        if ((read_o !== base) || (exp_q.size() != 0)) begin
            $display("FAIL random_glitch: read=%h queue=%0d, required %h and 0", read_o, exp_q.size(), base);
        end else begin
            passes++;
        end
    endtask

    task automatic test_clear_collision();
        int m;
        @(negedge clk);
        clear = 8'hFF;
        tick();
        @(negedge clk);
        clear = 8'h00;
        checks++;
        if ({changed, irq} !== 9'h0) begin
            $display("FAIL clear_all: changed=%h irq=%b, required 00 0", changed, irq);
        end else begin
            passes++;
        end
        pins = 8'h20;
        m = edge_cnt;
        exp_q.push_back(pack_evt(m + 6, 8'h00, 8'h01));
        repeat (5) tick();
        @(negedge clk);
        clear = 8'h01;
        tick();
        checks++;
        if ({read_o, changed, irq} !== {8'h20, 8'h01, 1'b1}) begin
            $display("FAIL set_beats_clear: read=%h changed=%h irq=%b, required 20 01 1", read_o, changed, irq);
        end else begin
            passes++;
        end
        @(negedge clk);
        clear = 8'h00;
        repeat (2) tick();
        @(negedge clk);
        clear = 8'h01;
        tick();
        checks++;
        if ({changed, irq} !== 9'h0) begin
            $display("FAIL idle_clear: changed=%h irq=%b, required 00 0", changed, irq);
        end else begin
            passes++;
        end
        @(negedge clk);
        clear = 8'h00;
        checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL clear_missing: %0d pulses outstanding, required 0", exp_q.size());
        end else begin
            passes++;
        end
    endtask

    task automatic test_reset_mid();
        int r;
        @(negedge clk);
        pins = 8'hFF;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({read_o, rise, fall, changed, irq} !== 33'h0) begin
            $display("FAIL reset_async: read=%h changed=%h irq=%b, required all 0", read_o, changed, irq);
        end else begin
            passes++;
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        r = edge_cnt;
        exp_q.push_back(pack_evt(r + 6, 8'hFF, 8'h00));
        repeat (5) tick();
        checks++;
        if (read_o !== 8'h00) begin
            $display("FAIL reset_latency: read=%h, required 00", read_o);
        end else begin
            passes++;
        end
        tick();
        checks++;
        if ({read_o, changed, irq} !== {8'hFF, 8'hFF, 1'b1}) begin
            $display("FAIL reset_accept: read=%h changed=%h irq=%b, required FF FF 1", read_o, changed, irq);
        end else begin
            passes++;
        end
        repeat (4) tick();
        checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL reset_missing: %0d pulses outstanding, required 0", exp_q.size());
        end else begin
            passes++;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_rise();
        test_glitch_reject();
        test_bounce();
        test_random_glitch();
        test_clear_collision();
        test_reset_mid();
        repeat (2) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
